// File: rtl/williams_blt_mem_arb_if.sv
// Bus bundle between the blitter/CPU/memory and the blitter memory arbiter.
// Handshake: blitter holds blt_rd or blt_wr (with address/data) until blt_ack; ack then holds until an en_e_n=1 edge.
interface williams_blt_mem_arb_if;
  logic        en_e_n;
  logic        blt_halt;
  logic        cpu_ba;
  logic        cpu_halt_n;
  logic        halt_ack;
  logic        blt_rd;
  logic        blt_wr;
  logic [15:0] blt_addr;
  logic [7:0]  blt_wdata;
  logic [1:0]  blt_nib_en;
  logic        blt_ack;
  logic [7:0]  blt_rdata;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;

  modport slave (
    input  en_e_n, blt_halt, cpu_ba, blt_rd, blt_wr, blt_addr, blt_wdata, blt_nib_en,
           cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_halt_n, halt_ack, blt_ack, blt_rdata, cpu_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output en_e_n, blt_halt, cpu_ba, blt_rd, blt_wr, blt_addr, blt_wdata, blt_nib_en,
           cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_halt_n, halt_ack, blt_ack, blt_rdata, cpu_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/williams_blt_mem_arb.sv
// Blitter/CPU memory arbiter: halts the CPU, then runs blitter reads, writes and
// nibble-masked read-modify-writes with a fixed strobe width.
module williams_blt_mem_arb #(
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  williams_blt_mem_arb_if.slave   bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT_WAIT, S_BLT_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_ACK
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] rdata_q;
  logic [7:0] merge_q;
  logic       cpu_halt_n_q;
  logic       halt_ack_q;
  logic       blt_ack_q;
  logic [7:0] merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      rdata_q      <= 8'h00;
      merge_q      <= 8'h00;
      cpu_halt_n_q <= 1'b1;
      halt_ack_q   <= 1'b0;
      blt_ack_q    <= 1'b0;
    end else begin
      cpu_halt_n_q <= !bus.blt_halt;
      case (state)
        S_IDLE: if (bus.blt_halt) state <= S_GRANT_WAIT;
        S_GRANT_WAIT: begin
          if (bus.blt_halt && bus.cpu_ba) begin
            state      <= S_BLT_IDLE;
            halt_ack_q <= 1'b1;
          end else if (!bus.blt_halt) begin
            state <= S_IDLE;
          end
        end
        // cpu_ba is deliberately not looked at again until the bus is handed back.
        S_BLT_IDLE: begin
          cnt <= 4'd0;
          if (!bus.blt_halt) begin
            state      <= S_IDLE;
            halt_ack_q <= 1'b0;
          end else if (bus.blt_rd) begin
            state <= S_RD;
          end else if (bus.blt_wr) begin
            case (bus.blt_nib_en)
              2'b11:        state <= S_WR;
              2'b01, 2'b10: state <= S_RMW_RD;
              default: begin
                state     <= S_ACK;
                blt_ack_q <= 1'b1;
              end
            endcase
          end
        end
        S_RD: begin
          if (cnt == LAST) begin
            rdata_q   <= bus.mem_rdata;
            state     <= S_ACK;
            blt_ack_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WR, S_RMW_WR: begin
          if (cnt == LAST) begin
            state     <= S_ACK;
            blt_ack_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RMW_RD: begin
          if (cnt == LAST) begin
            merge_q <= bus.mem_rdata;
            state   <= S_RMW_WR;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ACK: begin
          if (bus.en_e_n) begin
            state     <= S_BLT_IDLE;
            blt_ack_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign merged = {bus.blt_nib_en[1] ? bus.blt_wdata[7:4] : merge_q[7:4],
                   bus.blt_nib_en[0] ? bus.blt_wdata[3:0] : merge_q[3:0]};

  // The CPU owns the memory bus combinationally only while the arbiter is idle.
  always_comb begin
    if (state == S_IDLE) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_rd    = !bus.cpu_we;
      bus.mem_wr    = bus.cpu_we && bus.en_e_n;
    end else begin
      bus.mem_addr  = bus.blt_addr;
      bus.mem_wdata = (state == S_RMW_WR) ? merged : bus.blt_wdata;
      bus.mem_rd    = (state == S_RD) || (state == S_RMW_RD);
      bus.mem_wr    = (state == S_WR) || (state == S_RMW_WR);
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_halt_n = cpu_halt_n_q;
  assign bus.halt_ack   = halt_ack_q;
  assign bus.blt_ack    = blt_ack_q;
  assign bus.blt_rdata  = rdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_williams_blt_mem_arb.sv
// Randomized bench for williams_blt_mem_arb against a byte-array memory reference model.
module tb_williams_blt_mem_arb;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  williams_blt_mem_arb_if bus();
  logic [2:0] dbg_state;

  williams_blt_mem_arb #(.WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // Memory seen by the DUT, plus a preload port used only while in reset
  logic [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Reference model state
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;
  logic [15:0] cur_addr;

  // Bus monitor: cumulative strobe counters
  int rd_cyc = 0, wr_cyc = 0, any_wr = 0, both_hi = 0, addr_bad = 0;
  logic [7:0] last_wdata = 8'h00;
  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_wr) both_hi++;
    if (bus.halt_ack && bus.mem_rd) rd_cyc++;
    if (bus.halt_ack && bus.mem_wr) begin
      wr_cyc++;
      last_wdata = bus.mem_wdata;
    end
    if (bus.mem_wr) any_wr++;
    if (bus.halt_ack && (bus.mem_rd || bus.mem_wr) && bus.mem_addr != cur_addr) addr_bad++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One blitter access from BLT_IDLE through ACK release
  task automatic blt_txn(input bit is_rd, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [1:0] nib, input bit drop_halt);
    int rd0, wr0, n, exp_rd, exp_wr;
    logic [7:0] old, mask;
    bit got_ack;
    old  = ref_mem[addr];
    mask = (nib[1] ? 8'hF0 : 8'h00) | (nib[0] ? 8'h0F : 8'h00);
    if (is_rd) begin
      exp_rd = W + 1; exp_wr = 0;
      exp_q.push_back(old);
    end else begin
      exp_rd = (nib == 2'b01 || nib == 2'b10) ? W + 1 : 0;
      exp_wr = (nib == 2'b00) ? 0 : W + 1;
      if (nib != 2'b00) ref_mem[addr] = (wd & mask) | (old & ~mask);
    end
    cur_addr = addr;
    rd0 = rd_cyc; wr0 = wr_cyc;
    bus.blt_addr = addr; bus.blt_wdata = wd; bus.blt_nib_en = nib;
    bus.blt_rd = is_rd; bus.blt_wr = !is_rd; bus.en_e_n = 1'b0;
    got_ack = 1'b0; n = 0;
    while (!got_ack && n < 100) begin
      tick();
      n++;
      if (drop_halt && n == 1) bus.blt_halt = 1'b0;
      if (bus.blt_ack) got_ack = 1'b1;
    end
    check("ack_seen", got_ack, 1);
    bus.blt_rd = 1'b0; bus.blt_wr = 1'b0;
    check("rd_cycles", rd_cyc - rd0, exp_rd);
    check("wr_cycles", wr_cyc - wr0, exp_wr);
    if (is_rd) begin
      last_rd = exp_q.pop_front();
      check("rdata", bus.blt_rdata, last_rd);
    end else begin
      check("rdata_hold", bus.blt_rdata, last_rd);
      if (nib != 2'b00) check("wdata", last_wdata, ref_mem[addr]);
    end
    tick();
    check("ack_hold", bus.blt_ack, 1);
    bus.en_e_n = 1'b1;
    tick();
    bus.en_e_n = 1'b0;
    check("ack_drop", bus.blt_ack, 0);
    check("mem_content", mem[addr], ref_mem[addr]);
    if (drop_halt) begin
      tick();
      check("drop_halt_ack", bus.halt_ack, 0);
      check("drop_cpu_addr", bus.mem_addr, bus.cpu_addr);
      check("drop_cpu_halt_n", bus.cpu_halt_n, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wr0;
    bus.en_e_n = 1'b0; bus.blt_halt = 1'b0; bus.cpu_ba = 1'b0;
    bus.blt_rd = 1'b0; bus.blt_wr = 1'b0; bus.blt_addr = 16'h0; bus.blt_wdata = 8'h0;
    bus.blt_nib_en = 2'b00; bus.cpu_addr = 16'h0801; bus.cpu_wdata = 8'h00; bus.cpu_we = 1'b0;
    pre_we = 1'b0; pre_addr = 16'h0; pre_data = 8'h0;
    last_rd = 8'h00; cur_addr = 16'h0;
    tick();

    // Preload a window of memory while held in reset
    for (int a = 0; a < 258; a++) begin
      pre_we   = 1'b1;
      pre_addr = (a == 256) ? 16'h1234 : 16'h0800 + 16'(a);
      pre_data = (a == 256) ? 8'hA5 : (a == 257) ? 8'h97 : 8'($urandom);
      if (a == 257) pre_addr = 16'h0800;
      ref_mem[pre_addr] = pre_data;
      tick();
    end
    pre_we = 1'b0;

    // Reset state, with a halt request present
    bus.blt_halt = 1'b1;
    tick();
    check("rst_cpu_halt_n", bus.cpu_halt_n, 1);
    check("rst_halt_ack", bus.halt_ack, 0);
    check("rst_blt_ack", bus.blt_ack, 0);
    check("rst_blt_rdata", bus.blt_rdata, 8'h00);
    check("rst_mem_rd", bus.mem_rd, 1);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_addr", bus.mem_addr, 16'h0801);
    bus.blt_halt = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // CPU path while idle
    bus.cpu_addr = 16'h0810; bus.cpu_we = 1'b0;
    #1;
    check("cpu_rd", bus.mem_rd, 1);
    check("cpu_addr", bus.mem_addr, 16'h0810);
    check("cpu_rdata", bus.cpu_rdata, ref_mem[16'h0810]);
    bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h5A; bus.en_e_n = 1'b0;
    #1;
    check("cpu_wr_gated", bus.mem_wr, 0);
    bus.en_e_n = 1'b1;
    #1;
    check("cpu_wr", bus.mem_wr, 1);
    check("cpu_rd_low", bus.mem_rd, 0);
    ref_mem[16'h0810] = 8'h5A;
    tick();
    bus.cpu_we = 1'b0; bus.en_e_n = 1'b0;
    #1;
    check("cpu_readback", bus.cpu_rdata, ref_mem[16'h0810]);

    // Grant: halt now, bus-available three clocks later
    bus.blt_halt = 1'b1; bus.cpu_ba = 1'b0;
    tick();
    check("grant_cpu_halt_n", bus.cpu_halt_n, 0);
    check("grant_wait_ack0", bus.halt_ack, 0);
    tick(); tick();
    check("grant_wait_ack0b", bus.halt_ack, 0);
    check("grant_wait_strobes", bus.mem_rd | bus.mem_wr, 0);
    bus.cpu_ba = 1'b1;
    tick();
    check("grant_halt_ack", bus.halt_ack, 1);
    bus.cpu_ba = 1'b0;

    // Directed accesses
    blt_txn(1'b1, 16'h1234, 8'h00, 2'b00, 1'b0);
    check("rd_a5", bus.blt_rdata, 8'hA5);
    blt_txn(1'b0, 16'h0800, 8'h3C, 2'b10, 1'b0);
    check("rmw_37", mem[16'h0800], 8'h37);
    blt_txn(1'b0, 16'h0805, 8'hFF, 2'b00, 1'b0);

    // Random accesses
    for (int i = 0; i < 24; i++) begin
      blt_txn(1'($urandom_range(0, 1)), 16'h0800 + 16'($urandom_range(0, 255)),
              8'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Halt dropped mid-read
    blt_txn(1'b1, 16'h0800 + 16'($urandom_range(0, 255)), 8'h00, 2'b00, 1'b1);

    // Reset during the second cycle of a full write
    bus.blt_halt = 1'b1; bus.cpu_ba = 1'b1;
    n = 0;
    while (!bus.halt_ack && n < 20) begin tick(); n++; end
    check("regrant", bus.halt_ack, 1);
    cur_addr = 16'h0820;
    bus.blt_addr = 16'h0820; bus.blt_wdata = 8'hC3; bus.blt_nib_en = 2'b11; bus.blt_wr = 1'b1;
    n = 0;
    while (!bus.mem_wr && n < 20) begin tick(); n++; end
    check("wr_started", bus.mem_wr, 1);
    tick();
    check("wr_second_cycle", bus.mem_wr, 1);
    ref_mem[16'h0820] = 8'hC3;
    rst = 1'b1;
    tick();
    check("rst_mid_mem_wr", bus.mem_wr, 0);
    check("rst_mid_halt_ack", bus.halt_ack, 0);
    check("rst_mid_blt_ack", bus.blt_ack, 0);
    check("rst_mid_cpu_halt_n", bus.cpu_halt_n, 1);
    check("rst_mid_rdata", bus.blt_rdata, 8'h00);
    rst = 1'b0; bus.blt_halt = 1'b0; bus.blt_wr = 1'b0; bus.cpu_ba = 1'b0;
    wr0 = any_wr;
    for (int i = 0; i < 8; i++) tick();
    check("no_wr_after_rst", any_wr - wr0, 0);
    check("mem_after_rst", mem[16'h0820], ref_mem[16'h0820]);

    check("rd_wr_overlap", both_hi, 0);
    check("strobe_addr", addr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
